// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter
// Bit-serial adder shared by two requesters. A round-robin arbiter picks one
// operand pair at a time. One implication-logic full-adder cell is stepped
// LSB-first for WIDTH cycles, with the carry kept in a register. The sum,
// carry-out and owner ID are then offered on a valid/ready result port.
//
// Ports:
//   clk, rst                         clock (rising edge), async active-high reset
//   req{0,1}_valid/_a/_b/_cin        requester operand pair and carry-in
//   req{0,1}_ready                   operand accept (combinational, IDLE only)
//   res_valid/_sum/_cout/_id         result and owning requester
//   res_ready                        consumer accepts the result
//   busy                             controller is not IDLE
`timescale 1ns/1ps

// Full adder built only from material implication (x -> y = ~x | y) and negation.
module full_adder_imply (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    function automatic logic imp(input logic x, input logic y);
        return ~x | y;
    endfunction

    logic p;
    logic g;
    logic t;

    always_comb begin
        p    = ~(imp(a, b) & imp(b, a));      // a ^ b
        g    = ~imp(a, ~b);                   // a & b
        t    = ~imp(p, ~cin);                 // (a ^ b) & cin
        sum  = ~(imp(p, cin) & imp(cin, p));  // p ^ cin
        cout = imp(~g, t);                    // g | t
    end
endmodule

module serial_add_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    input  logic             res_ready,
    output logic             busy
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             c;
    logic [CNT_W-1:0] cnt;
    logic             id;
    logic             ptr;

    logic             grant;
    logic             any_valid;
    logic             fa_sum;
    logic             fa_cout;

    // Grant: a lone valid requester wins; on contention the pointer decides.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant     = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ptr;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state == IDLE) && any_valid && !grant;
    assign req1_ready = (state == IDLE) && any_valid && grant;

    // The single shared adder cell.
    full_adder_imply u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Result port is a direct view of the working registers.
    assign res_sum  = s_sh;
    assign res_cout = c;
    assign res_id   = id;

    // Controller: accept, serial add over WIDTH cycles, hold result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            s_sh      <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            id        <= 1'b0;
            ptr       <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_valid && req0_ready) begin
                        a_sh  <= req0_a;
                        b_sh  <= req0_b;
                        c     <= req0_cin;
                        cnt   <= '0;
                        id    <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else if (req1_valid && req1_ready) begin
                        a_sh  <= req1_a;
                        b_sh  <= req1_b;
                        c     <= req1_cin;
                        cnt   <= '0;
                        id    <= 1'b1;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH steps.
                    s_sh <= (s_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= fa_cout;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        ptr       <= ~id;
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_arbiter.sv
// Bench for serial_add_arbiter: three builds (WIDTH 8, 1, 16) sharing clock
// and reset. Directed vectors, round-robin order, stall, abort and randomised
// traffic with a result scoreboard.
`timescale 1ns/1ps

module tb_serial_add_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]       v0, v1, c0, c1, rr;
    logic [2:0]       rdy0, rdy1, rv, rc, rid, bsy;
    logic [2:0][15:0] a0, b0, a1, b1, rs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          id;
        logic [15:0] a;
        logic [15:0] b;
        bit          cin;
        logic [15:0] sum;
        bit          cout;
    } vec_t;

    typedef struct {
        bit          id;
        logic [15:0] sum;
        bit          cout;
    } exp_t;

    exp_t sb[$];
    vec_t vt[6];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned W = (g == 0) ? 8 : ((g == 1) ? 1 : 16);
        logic [W-1:0] sum_w;
        serial_add_arbiter #(.WIDTH(W)) dut (
            .clk        (clk),
            .rst        (rst),
            .req0_valid (v0[g]),
            .req0_a     (a0[g][W-1:0]),
            .req0_b     (b0[g][W-1:0]),
            .req0_cin   (c0[g]),
            .req0_ready (rdy0[g]),
            .req1_valid (v1[g]),
            .req1_a     (a1[g][W-1:0]),
            .req1_b     (b1[g][W-1:0]),
            .req1_cin   (c1[g]),
            .req1_ready (rdy1[g]),
            .res_valid  (rv[g]),
            .res_sum    (sum_w),
            .res_cout   (rc[g]),
            .res_id     (rid[g]),
            .res_ready  (rr[g]),
            .busy       (bsy[g])
        );
        assign rs[g] = 16'(sum_w);
    end

    function automatic int unsigned width_of(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 1 : 16);
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name, input string why);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, why);
    endfunction

    function automatic exp_t model(input bit id, input int unsigned w,
                                   input logic [15:0] a, input logic [15:0] b, input bit cin);
        logic [16:0] m;
        logic [16:0] t;
        exp_t        e;
        m      = (17'd1 << w) - 17'd1;
        t      = 17'(a & m[15:0]) + 17'(b & m[15:0]) + 17'(cin);
        e.id   = id;
        e.sum  = t[15:0] & m[15:0];
        e.cout = t[w];
        return e;
    endfunction

    task automatic clear_inputs();
        v0 = '0; v1 = '0; c0 = '0; c1 = '0; rr = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One operation from a single requester, checking latency and result.
    task automatic single_op(input int k, input vec_t v, input string name);
        int   n;
        int   lat;
        exp_t e;
        exp_t got;
        @(negedge clk);
        rr[k] = 1'b1;
        if (v.id) begin
            v1[k] = 1'b1; a1[k] = v.a; b1[k] = v.b; c1[k] = v.cin;
        end else begin
            v0[k] = 1'b1; a0[k] = v.a; b0[k] = v.b; c0[k] = v.cin;
        end
        #1;
        n = 0;
        while (!(v.id ? rdy1[k] : rdy0[k]) && n < 40) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 40) begin
            fail({name, "_accept"}, "ready never asserted");
            v0[k] = 1'b0; v1[k] = 1'b0;
            return;
        end
        e.id = v.id; e.sum = v.sum; e.cout = v.cout;
        sb.push_back(e);
        @(posedge clk);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            v0[k] = 1'b0; v1[k] = 1'b0;
            #1;
            if (rv[k]) break;
            @(posedge clk);
            lat++;
        end
        if (!rv[k]) begin
            fail({name, "_result"}, "res_valid never rose");
            sb.delete();
            return;
        end
        chk({name, "_latency"}, lat, width_of(k));
        got = sb.pop_front();
        chk({name, "_sum"}, rs[k], got.sum);
        chk({name, "_cout"}, rc[k], got.cout);
        chk({name, "_id"}, rid[k], got.id);
        @(posedge clk);
        @(negedge clk); #1;
        chk({name, "_busy_after"}, bsy[k], 0);
        chk({name, "_valid_after"}, rv[k], 0);
        rr[k] = 1'b0;
    endtask

    // Streamed traffic with scoreboard; both=1 keeps both requesters valid and
    // checks strict alternation, bp=1 adds random result back-pressure.
    task automatic stream(input int k, input int nops, input bit both, input bit bp, input string name);
        int unsigned w;
        logic [15:0] m;
        int          launched, accepted, done, cyc;
        bit          p0, p1, turn;
        exp_t        got;
        w = width_of(k);
        m = 16'((17'd1 << w) - 17'd1);
        launched = 0; accepted = 0; done = 0; cyc = 0;
        p0 = 1'b0; p1 = 1'b0; turn = 1'b0;
        sb.delete();
        while (done < nops && cyc < 60 * nops + 100) begin
            @(negedge clk);
            if (!p0) v0[k] = 1'b0;
            if (!p1) v1[k] = 1'b0;
            if (!p0 && launched < nops && (both || $urandom_range(0, 2) == 0)) begin
                p0 = 1'b1; launched++;
                v0[k] = 1'b1; a0[k] = 16'($urandom) & m; b0[k] = 16'($urandom) & m; c0[k] = 1'($urandom);
            end
            if (!p1 && launched < nops && (both || $urandom_range(0, 2) == 0)) begin
                p1 = 1'b1; launched++;
                v1[k] = 1'b1; a1[k] = 16'($urandom) & m; b1[k] = 16'($urandom) & m; c1[k] = 1'($urandom);
            end
            rr[k] = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            chk({name, "_one_ready"}, 32'(rdy0[k] & rdy1[k]), 0);
            if (rv[k] && rr[k]) begin
                if (sb.size() == 0) begin
                    fail({name, "_spurious"}, "result with no outstanding operation");
                end else begin
                    got = sb.pop_front();
                    chk({name, "_sum"}, rs[k], got.sum);
                    chk({name, "_cout"}, rc[k], got.cout);
                    chk({name, "_id"}, rid[k], got.id);
                end
                done++;
            end
            if (v0[k] && rdy0[k]) begin
                sb.push_back(model(1'b0, w, a0[k], b0[k], c0[k]));
                if (both) begin chk({name, "_grant_order"}, 0, turn); turn = ~turn; end
                p0 = 1'b0; accepted++;
            end
            if (v1[k] && rdy1[k]) begin
                sb.push_back(model(1'b1, w, a1[k], b1[k], c1[k]));
                if (both) begin chk({name, "_grant_order"}, 1, turn); turn = ~turn; end
                p1 = 1'b0; accepted++;
            end
            cyc++;
        end
        if (done < nops) fail({name, "_drain"}, "timed out before all results returned");
        chk({name, "_accepted"}, accepted, nops);
        chk({name, "_results"}, done, nops);
        chk({name, "_queue_empty"}, sb.size(), 0);
        @(negedge clk);
        v0[k] = 1'b0; v1[k] = 1'b0; rr[k] = 1'b0;
    endtask

    // Result held under back-pressure, then the other requester is granted.
    task automatic stall_test();
        int n;
        pulse_reset();
        @(negedge clk);
        v0[0] = 1'b1; a0[0] = 16'h12; b0[0] = 16'h34; c0[0] = 1'b1;
        v1[0] = 1'b1; a1[0] = 16'hAA; b1[0] = 16'h55; c1[0] = 1'b0;
        rr[0] = 1'b0;
        #1;
        chk("stall_ready0", rdy0[0], 1);
        chk("stall_ready1", rdy1[0], 0);
        n = 0;
        while (!rv[0] && n < 30) begin @(negedge clk); #1; n++; end
        if (!rv[0]) begin
            fail("stall_result", "res_valid never rose");
            return;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("stall_valid", rv[0], 1);
            chk("stall_sum", rs[0], 16'h47);
            chk("stall_cout", rc[0], 0);
            chk("stall_id", rid[0], 0);
            chk("stall_no_ready", 32'({rdy0[0], rdy1[0]}), 0);
            chk("stall_busy", bsy[0], 1);
        end
        @(negedge clk);
        rr[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        chk("release_busy", bsy[0], 0);
        chk("release_valid", rv[0], 0);
        chk("release_ready1", rdy1[0], 1);
        chk("release_ready0", rdy0[0], 0);
        @(posedge clk);
        @(negedge clk);
        v0[0] = 1'b0; v1[0] = 1'b0;
        n = 0;
        while (!rv[0] && n < 30) begin @(negedge clk); n++; end
        if (!rv[0]) begin
            fail("release_result", "second result never arrived");
            return;
        end
        chk("release_sum", rs[0], 16'hFF);
        chk("release_cout", rc[0], 0);
        chk("release_id", rid[0], 1);
        @(posedge clk);
        @(negedge clk);
        rr[0] = 1'b0;
    endtask

    // Reset during RUN aborts the operation and the pointer restarts at 0.
    task automatic reset_mid_run();
        int n;
        bit seen;
        pulse_reset();
        @(negedge clk);
        v1[0] = 1'b1; a1[0] = 16'h0F; b1[0] = 16'hF0; c1[0] = 1'b1; rr[0] = 1'b1;
        #1;
        chk("abort_ready1", rdy1[0], 1);
        @(posedge clk);
        @(negedge clk);
        v1[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy_before", bsy[0], 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", bsy[0], 0);
        chk("abort_valid", rv[0], 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rv[0]) seen = 1'b1;
        end
        chk("abort_no_result", seen, 0);
        v0[0] = 1'b1; a0[0] = 16'h01; b0[0] = 16'h02; c0[0] = 1'b0;
        v1[0] = 1'b1; a1[0] = 16'h80; b1[0] = 16'h80; c1[0] = 1'b1;
        #1;
        chk("abort_next_ready0", rdy0[0], 1);
        chk("abort_next_ready1", rdy1[0], 0);
        @(posedge clk);
        @(negedge clk);
        v0[0] = 1'b0; v1[0] = 1'b0;
        n = 0;
        while (!rv[0] && n < 30) begin @(negedge clk); n++; end
        if (!rv[0]) begin
            fail("abort_next_result", "res_valid never rose");
            return;
        end
        chk("abort_next_sum", rs[0], 16'h03);
        chk("abort_next_cout", rc[0], 0);
        chk("abort_next_id", rid[0], 0);
        @(posedge clk);
        @(negedge clk);
        rr[0] = 1'b0;
    endtask

    initial begin
        vt[0] = '{1'b0, 16'h5A, 16'h3C, 1'b0, 16'h96, 1'b0};
        vt[1] = '{1'b1, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1};
        vt[2] = '{1'b1, 16'hFF, 16'hFF, 1'b1, 16'hFF, 1'b1};
        vt[3] = '{1'b0, 16'h7F, 16'h01, 1'b0, 16'h80, 1'b0};
        vt[4] = '{1'b1, 16'h80, 16'h80, 1'b0, 16'h00, 1'b1};
        vt[5] = '{1'b0, 16'h00, 16'h00, 1'b1, 16'h01, 1'b0};

        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_valid", rv[0], 0);
        chk("reset_sum", rs[0], 0);
        chk("reset_cout", rc[0], 0);
        chk("reset_id", rid[0], 0);
        chk("reset_busy", bsy[0], 0);
        v0[0] = 1'b1;
        #1;
        chk("reset_ready0", rdy0[0], 1);
        chk("reset_ready1", rdy1[0], 0);
        v0[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            single_op(0, vt[i], $sformatf("vec%0d", i));
        end

        pulse_reset();
        stream(0, 4, 1'b1, 1'b0, "round_robin");

        stall_test();
        reset_mid_run();

        pulse_reset();
        stream(1, 1000, 1'b0, 1'b1, "rnd_w1");
        stream(2, 1000, 1'b0, 1'b1, "rnd_w16");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_add_arbiter.md
# serial_add_arbiter

Bit-serial adder controller that shares a single `FullAdder_Imply` cell between two requesters. A round-robin arbiter grants one operand pair at a time. The controller then sequences the cell LSB-first over `WIDTH` cycles, keeping the carry in a register, and presents the `WIDTH`-bit sum, carry-out and requester ID on a valid/ready result port. It is the area-minimal arithmetic path of the imply-logic datapath: one adder cell, time-multiplexed.

## Interface
- `WIDTH`, default 8: operand/sum width in bits; legal range 1..64.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req0_valid`  in  1: requester 0 has an operand pair.
- `req0_a`, `req0_b`  in  `WIDTH`: requester 0 operands.
- `req0_cin`  in  1: requester 0 carry-in.
- `req0_ready`  out  1: requester 0 operands accepted this cycle when `req0_valid` is also high.
- `req1_valid`, `req1_a`, `req1_b`, `req1_cin`, `req1_ready`: same as requester 0, for requester 1.
- `res_valid`  out  1: result available.
- `res_sum`  out  `WIDTH`: (a + b + cin) mod 2^`WIDTH`.
- `res_cout`  out  1: bit `WIDTH` of a + b + cin.
- `res_id`  out  1: index of the requester that owns the result.
- `res_ready`  in  1: consumer accepts the result.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- States: IDLE, RUN, DONE.
- Registers:
  - operand shift registers `a_sh`, `b_sh` (`WIDTH` each)
  - sum shift register `s_sh` (`WIDTH`)
  - carry register `c` (1)
  - bit counter (clog2(`WIDTH`), minimum 1 bit)
  - owner `id` (1)
  - round-robin pointer `ptr` (1)
- Grant in IDLE (combinational):
  - If only one valid is high, that requester is granted.
  - If both are high, requester `ptr` is granted.
  - `reqN_ready` = (state == IDLE) && grant==N. At most one ready is high in any cycle. Ready never depends on the other requester's operand data.
- IDLE -> RUN on `reqN_valid && reqN_ready`: load `a_sh`/`b_sh` from requester N, `c` = `reqN_cin`, counter = 0, `id` = N.
- RUN, each cycle:
  - The full-adder cell sees `a_sh[0]`, `b_sh[0]`, `c`.
  - `s_sh` shifts right with the cell sum entering at MSB.
  - `a_sh`/`b_sh` shift right; `c` takes the cell carry; counter increments.
  - When counter == `WIDTH`-1, the next state is DONE.
- DONE:
  - `res_valid` = 1.
  - `res_sum` = `s_sh`, `res_cout` = `c`, `res_id` = `id`. All are held stable until the handshake.
  - On `res_valid && res_ready`: go to IDLE, `ptr` = ~`id`.
  - `res_ready` low stalls indefinitely, with no readies asserted.
- `res_sum`/`res_cout` are direct register views. They change during RUN and are meaningful only while `res_valid` is high. `res_id` changes only on accept.
- Requester inputs are ignored outside the accept cycle. Operand changes after acceptance have no effect.
- `WIDTH` = 1: RUN lasts exactly one cycle.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE, `ptr` = 0, counter 0, `c` 0, all shift registers 0, `id` 0.
  - `res_valid` 0, `res_sum` 0, `res_cout` 0, `res_id` 0, `busy` 0.
  - `req0_ready`/`req1_ready` revert to the IDLE combinational rule.
- Latency: with the accept edge as E0, RUN spans edges E1..E`WIDTH`. `res_valid` rises after edge E`WIDTH`, i.e. `WIDTH` cycles after the accept edge.
- Handshake edge returns to IDLE. The earliest next accept is on the following edge. Minimum period per operation is `WIDTH`+2 cycles.
- Reset mid-RUN or mid-DONE: the operation is aborted, no result is ever presented, and `ptr` returns to 0.
- Both requesters continuously valid: grants alternate 0,1,0,1,… starting with 0 after reset.
- `rst` deassertion is synchronous to `clk` at system level; it needs no internal synchronizer.

## Test plan
- WIDTH=8, req0 a=0x5A b=0x3C cin=0 -> `res_sum`=0x96, `res_cout`=0, `res_id`=0; `res_valid` rises exactly 8 cycles after the accept edge.
- req1 a=0xFF b=0x01 cin=0 -> `res_sum`=0x00, `res_cout`=1, `res_id`=1; then a=0xFF b=0xFF cin=1 -> 0xFF, `res_cout`=1.
- Both valid from reset, `res_ready` tied high, 4 operations -> `res_id` sequence 0,1,0,1. Only one ready per cycle; each result matches its owner's operands.
- `res_ready` held low for 5 cycles in DONE with both requesters valid -> `res_valid` and outputs stable, both readies low, `busy`=1. Release -> handshake, IDLE, then the other requester is granted.
- `rst` pulsed at the 3rd RUN cycle of req1's operation -> immediately `busy`=0, `res_valid`=0, no result produced. With both requesters valid next, req0 is granted.
- WIDTH=1 and WIDTH=16 builds: 1000 random operations from both requesters with random `res_ready` back-pressure -> every result equals the model a+b+cin, with no lost or duplicated operations.
